// File: rtl/msram_bank_array.sv
// Multi-bank single-port SRAM working buffer with per-bank read-valid and a zero-sweep clear engine.
// Optional per-word even parity is enabled by defining MSRAM_PARITY_EN.
module msram_bank_array #(
  parameter int NBANK = 16,
  parameter int DW    = 64,
  parameter int AW    = 12
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  output logic                busy_o,
  input  logic [NBANK-1:0]    en_i,
  input  logic [NBANK-1:0]    we_i,
  input  logic [NBANK*AW-1:0] addr_i,
  input  logic [NBANK*DW-1:0] d_i,
  output logic [NBANK*DW-1:0] q_o,
  output logic [NBANK-1:0]    qv_o,
  output logic [NBANK-1:0]    perr_o
);

  localparam int DEPTH = 2 ** AW;
`ifdef MSRAM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clearing;
  logic          access_ok;

  assign clearing  = (state_q == ST_CLEAR);
  // The cycle that launches a sweep discards all bank accesses.
  assign access_ok = (state_q == ST_IDLE) && !clr_i;
  assign busy_o    = clearing;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
    logic [MW-1:0] mem_q [DEPTH];
    logic [AW-1:0] bank_addr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] bank_d;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] q_q;
    logic          qv_q;

    assign bank_addr = addr_i[gi*AW +: AW];
    assign bank_d    = d_i[gi*DW +: DW];
    assign wr_en     = clearing | (access_ok & en_i[gi] & we_i[gi]);
    assign rd_en     = access_ok & en_i[gi] & ~we_i[gi];
    assign wr_addr   = clearing ? cnt_q : bank_addr;

`ifdef MSRAM_PARITY_EN
    assign wr_word = clearing ? '0 : {^bank_d, bank_d};
`else
    assign wr_word = clearing ? '0 : bank_d;
`endif

    // Memory contents survive reset; only the sweep zeroes them.
    always_ff @(posedge clk_i) begin
      if (wr_en) begin
        mem_q[wr_addr] <= wr_word;
      end
    end

    assign rd_word = mem_q[bank_addr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q_q  <= '0;
        qv_q <= 1'b0;
      end else begin
        qv_q <= rd_en;
        if (rd_en) begin
          q_q <= rd_word[DW-1:0];
        end
      end
    end

`ifdef MSRAM_PARITY_EN
    logic perr_q;
    // A stored word with even parity XORs to zero across data and parity bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        perr_q <= 1'b0;
      end else begin
        perr_q <= rd_en & (^rd_word);
      end
    end
    assign perr_o[gi] = perr_q;
`else
    assign perr_o[gi] = 1'b0;
`endif

    assign q_o[gi*DW +: DW] = q_q;
    assign qv_o[gi]         = qv_q;
  end

endmodule

// File: tb/tb_msram_bank_array.sv
// Directed self-checking bench for msram_bank_array at NBANK=4, DW=16, AW=4.
module tb_msram_bank_array;

  localparam int NBANK = 4;
  localparam int DW    = 16;
  localparam int AW    = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                clr_i;
  logic                busy_o;
  logic [NBANK-1:0]    en_i;
  logic [NBANK-1:0]    we_i;
  logic [NBANK*AW-1:0] addr_i;
  logic [NBANK*DW-1:0] d_i;
  logic [NBANK*DW-1:0] q_o;
  logic [NBANK-1:0]    qv_o;
  logic [NBANK-1:0]    perr_o;

  int checks = 0;
  int errors = 0;

  msram_bank_array #(.NBANK(NBANK), .DW(DW), .AW(AW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .busy_o (busy_o),
    .en_i   (en_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .d_i    (d_i),
    .q_o    (q_o),
    .qv_o   (qv_o),
    .perr_o (perr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    en_i   = '0;
    we_i   = '0;
    clr_i  = 1'b0;
    addr_i = '0;
    d_i    = '0;
  endtask

  task automatic acc(input int b, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] dd);
    en_i[b]            = 1'b1;
    we_i[b]            = w;
    addr_i[b*AW +: AW] = a;
    d_i[b*DW +: DW]    = dd;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int b, input int a);
    logic [3:0] bb;
    logic [3:0] aa;
    bb = 4'(b);
    aa = 4'(a);
    return {4'hC, bb, aa, 4'h3};
  endfunction

  function automatic logic [63:0] pat_row(input int a);
    return {pat(3, a), pat(2, a), pat(1, a), pat(0, a)};
  endfunction

  initial begin
    int bc;
    logic qv_seen;

    rst_ni = 1'b0;
    idle_in();
    step();
    step();
    rst_ni = 1'b1;
    step();
    chk("reset_q", q_o, 64'h0);
    chk("reset_qv", 64'(qv_o), 64'h0);
    chk("reset_busy", 64'(busy_o), 64'h0);
    chk("reset_perr", 64'(perr_o), 64'h0);

    // Two-bank write then read in the following cycle.
    idle_in();
    acc(0, 1'b1, 4'd3, 16'hA5A5);
    acc(2, 1'b1, 4'd3, 16'h1234);
    step();
    chk("write_qv", 64'(qv_o), 64'h0);
    idle_in();
    acc(0, 1'b0, 4'd3, 16'h0);
    acc(2, 1'b0, 4'd3, 16'h0);
    step();
    chk("read_q", q_o, 64'h0000_1234_0000_A5A5);
    chk("read_qv", 64'(qv_o), 64'h5);
    chk("read_perr", 64'(perr_o), 64'h0);

    // Write-only and disabled cycles hold Q.
    idle_in();
    acc(0, 1'b1, 4'd5, 16'h0BAD);
    step();
    chk("wonly_q", q_o, 64'h0000_1234_0000_A5A5);
    chk("wonly_qv", 64'(qv_o), 64'h0);
    idle_in();
    step();
    chk("noen_q", q_o, 64'h0000_1234_0000_A5A5);
    chk("noen_qv", 64'(qv_o), 64'h0);
    acc(0, 1'b0, 4'd5, 16'h0);
    step();
    chk("wr_rd_q", q_o, 64'h0000_1234_0000_0BAD);
    chk("wr_rd_qv", 64'(qv_o), 64'h1);

    // Fill everything, then sweep with a discarded bank1 write on the CLR cycle.
    for (int a = 0; a < 16; a++) begin
      idle_in();
      for (int b = 0; b < NBANK; b++) acc(b, 1'b1, 4'(a), pat(b, a));
      step();
    end
    idle_in();
    acc(1, 1'b1, 4'd7, 16'hFFFF);
    clr_i = 1'b1;
    step();
    chk("clr_busy", 64'(busy_o), 64'h1);
    bc = 0;
    qv_seen = 1'b0;
    while (busy_o && bc < 40) begin
      bc++;
      idle_in();
      for (int b = 0; b < NBANK; b++) acc(b, bc[0], 4'(bc), 16'hFFFF);
      clr_i = 1'b1;
      step();
      qv_seen = qv_seen | (|qv_o);
    end
    chk("busy_len", 64'(bc), 64'd16);
    chk("sweep_qv", 64'(qv_seen), 64'h0);
    chk("sweep_q_hold", q_o, 64'h0000_1234_0000_0BAD);
    for (int a = 0; a < 16; a++) begin
      idle_in();
      for (int b = 0; b < NBANK; b++) acc(b, 1'b0, 4'(a), 16'h0);
      step();
      chk($sformatf("cleared_a%0d", a), q_o, 64'h0);
      if (a == 0) chk("cleared_qv", 64'(qv_o), 64'hF);
    end

    // Refill, start a sweep, and abort it with reset after five clear writes.
    for (int a = 0; a < 16; a++) begin
      idle_in();
      for (int b = 0; b < NBANK; b++) acc(b, 1'b1, 4'(a), pat(b, a));
      step();
    end
    idle_in();
    clr_i = 1'b1;
    step();
    idle_in();
    for (int k = 0; k < 5; k++) step();
    chk("abort_busy_pre", 64'(busy_o), 64'h1);
    rst_ni = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_o), 64'h0);
    chk("abort_q", q_o, 64'h0);
    step();
    rst_ni = 1'b1;
    step();
    for (int a = 0; a < 16; a++) begin
      idle_in();
      for (int b = 0; b < NBANK; b++) acc(b, 1'b0, 4'(a), 16'h0);
      step();
      chk($sformatf("abort_a%0d", a), q_o, (a < 5) ? 64'h0 : pat_row(a));
    end

`ifdef MSRAM_PARITY_EN
    idle_in();
    acc(0, 1'b1, 4'd2, 16'h0001);
    step();
    idle_in();
    dut.g_bank[0].mem_q[2] = 17'h1_0003;
    acc(0, 1'b0, 4'd2, 16'h0);
    step();
    chk("par_bad_qv", 64'(qv_o), 64'h1);
    chk("par_bad_perr", 64'(perr_o), 64'h1);
    idle_in();
    acc(0, 1'b1, 4'd2, 16'h0001);
    step();
    idle_in();
    acc(0, 1'b0, 4'd2, 16'h0);
    step();
    chk("par_ok_q", 64'(q_o[15:0]), 64'h0001);
    chk("par_ok_perr", 64'(perr_o), 64'h0);
`else
    chk("noparity_perr", 64'(perr_o), 64'h0);
`endif

    idle_in();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
